uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO, and the next-generation serial TX for the board's PC link. Compared with the first-generation transmitter, it has the following decided features:
- configurable bit period, data width, parity and stop bits;
- a valid/ready byte input;
- a frame-aligned baud counter instead of a free-running derived clock;
- gap-free back-to-back frames.

It sits between the ADC readout/packetiser logic and the board's RS-232 TXD pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity modes, FSM encoding and
// a frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int n_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and extra-bit pointers
// so that full and empty stay distinguishable at wrap-around.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign data_out = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are sent back-to-back with a baud
// counter that restarts at every frame so bit edges align to the start bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  // Handshake: a word is taken on a rising edge where tx_valid && tx_ready;
  // tx_ready is simply !full, so the producer may hold tx_valid indefinitely.
  logic [2:0]           state;
  logic [BW-1:0]        baud;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 txd_q;

  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 par_next;
  logic                 baud_last;
  logic                 data_last;
  logic                 stop_last;
  logic                 frame_end;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (tx_valid),
    .data_in  (tx_data),
    .pop      (pop),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign data_last = (bit_cnt == 4'(DATA_BITS - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end = (state == ST_STOP) && baud_last && stop_last;

  // The head word is taken either from idle or on the very last cycle of a
  // frame, which is what removes the gap between consecutive frames.
  assign pop      = !empty && ((state == ST_IDLE) || frame_end);
  assign par_next = (PARITY == PAR_ODD) ? ~^head : ^head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      if (pop) begin
        shreg   <= head;
        par_bit <= par_next;
        bit_cnt <= '0;
      end
      case (state)
        ST_IDLE: begin
          baud <= '0;
          if (pop) begin
            state <= ST_START;
            txd_q <= 1'b0;
          end else begin
            txd_q <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud  <= '0;
            state <= ST_DATA;
            txd_q <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (data_last) begin
              stop_cnt <= 1'b0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                txd_q <= par_bit;
              end else begin
                state <= ST_STOP;
                txd_q <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              txd_q   <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baud_last) begin
            baud     <= '0;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
            txd_q    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (stop_last) begin
              if (pop) begin
                state <= ST_START;
                txd_q <= 1'b0;
              end else begin
                state <= ST_IDLE;
                txd_q <= 1'b1;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = (state != ST_IDLE);
  assign frame_done = frame_end;
  assign tx_ready   = !full;

endmodule
